// File: rtl/display_rot_pkg.sv
// rtl/display_rot_pkg.sv - shared constants and select helpers for the rotating-character display
package display_rot_pkg;

   localparam logic [0:0] ST_PAUSE = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam logic [1:0] SEL_0   = 2'd0;
   localparam logic [1:0] SEL_1   = 2'd1;
   localparam logic [1:0] SEL_2   = 2'd2;
   localparam logic [1:0] SEL_MAX = 2'd2;

   localparam int TICK_DIV_DEF = 50_000_000;

   function automatic logic [1:0] sel_fwd(input logic [1:0] s);
      return (s >= SEL_MAX) ? SEL_0 : s + 2'd1;
   endfunction

   function automatic logic [1:0] sel_rev(input logic [1:0] s);
      return (s == SEL_0 || s > SEL_MAX) ? SEL_MAX : s - 2'd1;
   endfunction

   // the illegal code 3 maps to 0 so sel never leaves 0..2
   function automatic logic [1:0] sel_clamp(input logic [1:0] s);
      return (s > SEL_MAX) ? SEL_0 : s;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running period counter with a terminal-count pulse
module tick_divider
   import display_rot_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tc
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // a clear in the same cycle as terminal count swallows the pulse
   assign tc = enable & ~clear & (cnt == LAST);

   always_ff @(posedge CLOCK_50) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_rotation_ctrl.sv
// rtl/display_rotation_ctrl.sv - timed 0/1/2 rotation select with pause, step and load
// Optional reverse rotation via `ROT_REVERSE_EN (dir input is ignored when undefined).
module display_rotation_ctrl
   import display_rot_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       run,
   input  logic       dir,
   input  logic       step_n,
   input  logic       load,
   input  logic [1:0] load_sel,
   output logic [1:0] sel,
   output logic       tick,
   output logic       running
);

   logic [0:0] state;
   logic       step_prev;
   logic       step_req;
   logic       in_run;
   logic       div_clear;
   logic       adv_tc;
   logic       step_edge;
   logic       do_step;
   logic       do_adv;
   logic [1:0] sel_next;

   assign in_run  = (state == ST_RUN);
   assign running = in_run;

   // period restarts on load, while paused and on the way out of RUN
   assign div_clear = load | ~in_run | ~run;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .enable   (in_run),
      .clear    (div_clear),
      .tc       (adv_tc)
   );

   assign step_edge = step_prev & ~step_n;
   assign do_step   = step_req & ~in_run & ~load;
   assign do_adv    = ~load & (adv_tc | do_step);

`ifdef ROT_REVERSE_EN
   assign sel_next = dir ? sel_rev(sel) : sel_fwd(sel);
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign sel_next   = sel_fwd(sel);
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= ST_PAUSE;
         sel       <= SEL_0;
         tick      <= 1'b0;
         step_prev <= 1'b1;
         step_req  <= 1'b0;
      end else begin
         state     <= run ? ST_RUN : ST_PAUSE;
         step_prev <= step_n;
         // the edge is latched for one cycle, giving the step its fixed latency
         step_req  <= step_edge & ~in_run & ~load;
         tick      <= do_adv;
         if (load) begin
            sel <= sel_clamp(load_sel);
         end else if (do_adv) begin
            sel <= sel_next;
         end
      end
   end

endmodule

// File: tb/tb_display_rotation_ctrl.sv
// tb/tb_display_rotation_ctrl.sv - randomized bench for display_rotation_ctrl against a behavioural model
module tb_display_rotation_ctrl;

   localparam int TD = 4;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic       run      = 1'b0;
   logic       dir      = 1'b0;
   logic       step_n   = 1'b1;
   logic       load     = 1'b0;
   logic [1:0] load_sel = 2'd0;
   logic [1:0] sel;
   logic       tick;
   logic       running;

   int total = 0;
   int bad   = 0;
   int ntick = 0;
   int seen[$];

   int m_sel  = 0;
   int m_cnt  = 0;
   bit m_run  = 0;
   bit m_prev = 1;
   bit m_pend = 0;
   bit m_tick = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   display_rotation_ctrl #(.TICK_DIV(TD)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .run      (run),
      .dir      (dir),
      .step_n   (step_n),
      .load     (load),
      .load_sel (load_sel),
      .sel      (sel),
      .tick     (tick),
      .running  (running)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int rot(input int s, input bit d);
`ifdef ROT_REVERSE_EN
      if (d) return (s + 2) % 3;
`endif
      return (s + 1) % 3;
   endfunction

   // one clock edge of the reference behaviour, using the inputs presented before that edge
   task automatic model_edge();
      bit adv;
      bit pend_new;
      if (reset) begin
         m_sel = 0; m_cnt = 0; m_run = 0; m_prev = 1; m_pend = 0; m_tick = 0;
         return;
      end
      adv      = 0;
      pend_new = !m_run && m_prev && !step_n && !load;
      if (load) begin
         m_sel = (load_sel == 2'd3) ? 0 : int'(load_sel);
         m_cnt = 0;
      end else begin
         if (m_run && run) begin
            if (m_cnt == TD - 1) begin
               adv   = 1;
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end else begin
            m_cnt = 0;
         end
         if (m_pend && !m_run) adv = 1;
      end
      if (adv) m_sel = rot(m_sel, dir);
      m_tick = adv;
      m_run  = run;
      m_prev = step_n;
      m_pend = pend_new;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK_50);
         model_edge();
         #1;
         check("sel", sel, m_sel);
         check("tick", tick, m_tick);
         check("running", running, m_run);
         if (tick === 1'b1) begin
            ntick++;
            seen.push_back(int'(sel));
         end
      end
   endtask

   task automatic check_seq(input string tag, input int e0, input int e1, input int e2, input int e3, input int n);
      int exp[4];
      exp = '{e0, e1, e2, e3};
      check({tag, "_len"}, seen.size(), n);
      for (int i = 0; i < n; i++)
         check(tag, (seen.size() > i) ? seen[i] : -1, exp[i]);
   endtask

   initial begin
      // reset state
      reset = 1'b1;
      cyc(2);
      check("rst_sel", sel, 0);
      check("rst_tick", tick, 0);
      check("rst_running", running, 0);
      reset = 1'b0;

      // idle in PAUSE
      ntick = 0;
      cyc(20);
      check("idle_ticks", ntick, 0);
      check("idle_sel", sel, 0);

      // forward auto-rotate
      seen.delete();
      run = 1'b1;
      cyc(1);
      check("run_up", running, 1);
      cyc(16);
      check_seq("fwd_seq", 1, 2, 0, 1, 4);

      // reverse auto-rotate from sel=0
      run = 1'b0; reset = 1'b1;
      cyc(1);
      reset = 1'b0; dir = 1'b1; run = 1'b1;
      seen.delete();
      cyc(13);
`ifdef ROT_REVERSE_EN
      check_seq("rev_seq", 2, 1, 0, 0, 3);
`else
      check_seq("rev_seq", 1, 2, 0, 0, 3);
`endif

      // held-low step in PAUSE
      run = 1'b0; dir = 1'b0; reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(1);
      ntick = 0;
      step_n = 1'b0;
      cyc(1);
      check("step_lat0", tick, 0);
      cyc(1);
      check("step_tick", tick, 1);
      check("step_sel", sel, 1);
      cyc(8);
      check("step_once", ntick, 1);
      step_n = 1'b1;
      cyc(1);

      // step during RUN is ignored
      run = 1'b1;
      ntick = 0;
      cyc(2);
      step_n = 1'b0;
      cyc(2);
      step_n = 1'b1;
      cyc(2);
      check("run_step_ticks", ntick, 1);
      check("run_step_sel", sel, 2);

      // load mid-period restarts the count
      load = 1'b1; load_sel = 2'd1;
      cyc(1);
      check("load1_sel", sel, 1);
      load = 1'b0;
      cyc(2);
      load = 1'b1; load_sel = 2'd2;
      cyc(1);
      check("load2_sel", sel, 2);
      check("load2_tick", tick, 0);
      load = 1'b0;
      cyc(3);
      check("load2_hold", sel, 2);
      cyc(1);
      check("load2_adv_tick", tick, 1);
      check("load2_adv_sel", sel, 0);

      // load of 3 clamps
      load = 1'b1; load_sel = 2'd3;
      cyc(1);
      check("load3_sel", sel, 0);
      check("load3_tick", tick, 0);
      load = 1'b0;

      // load coinciding with a step edge
      run = 1'b0;
      cyc(2);
      step_n = 1'b0; load = 1'b1; load_sel = 2'd2;
      cyc(1);
      load = 1'b0;
      ntick = 0;
      cyc(3);
      check("coll_sel", sel, 2);
      check("coll_ticks", ntick, 0);
      step_n = 1'b1;
      cyc(1);

      // reset during RUN at count 2
      run = 1'b1;
      cyc(3);
      reset = 1'b1;
      cyc(1);
      check("rst_run_sel", sel, 0);
      check("rst_run_tick", tick, 0);
      check("rst_run_running", running, 0);
      reset = 1'b0; run = 1'b0;
      cyc(1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) run = ~run;
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         if ($urandom_range(0, 5) == 0) step_n = ~step_n;
         load     = ($urandom_range(0, 11) == 0);
         load_sel = 2'($urandom_range(0, 3));
         cyc(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
